// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter.
// Holds the operand width and the FSM state encoding.
package addsub_arb_pkg;

    localparam int W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/addsub.sv
// Registered 8-bit adder/subtractor: o <= a + b (s=0) or a - b mod 2^9 (s=1).
// Carries no reset; its output is only observed once the arbiter marks it valid.
module addsub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W:0]   o
);

    always_ff @(posedge clk) begin
        if (s) begin
            o <= {1'b0, a} - {1'b0, b};
        end else begin
            o <= {1'b0, a} + {1'b0, b};
        end
    end

endmodule

// File: rtl/addsub_arb.sv
// Arbitrates two requesters onto one shared addsub, one operation in flight.
// Define ADDSUB_ARB_RR_EN for round-robin; otherwise req0 has fixed priority.
module addsub_arb
    import addsub_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req0_s,
    input  logic         req1_s,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   res_data,
    output logic         res_id,
    output logic         busy
);

    state_t       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         s_q;
    logic         id_q;
    logic         gnt0;
    logic         gnt1;

`ifdef ADDSUB_ARB_RR_EN
    // last_q holds the index granted most recently; reset to 1 so req0 wins first.
    logic last_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && (gnt0 || gnt1)) begin
            last_q <= gnt1;
        end
    end
`else
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    // Ready is withheld while reset is asserted so no handshake is seen during reset.
    assign req0_ready = rst_n && (state_q == IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == IDLE) && gnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        a_q     <= gnt1 ? req1_a : req0_a;
                        b_q     <= gnt1 ? req1_b : req0_b;
                        s_q     <= gnt1 ? req1_s : req0_s;
                        id_q    <= gnt1;
                        state_q <= EXEC;
                    end
                end
                EXEC:    state_q <= RESP;
                RESP: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand regs stay frozen through RESP, so the registered sum stays stable.
    addsub #(.W(W)) u_addsub (
        .clk (clk),
        .a   (a_q),
        .b   (b_q),
        .s   (s_q),
        .o   (res_data)
    );

    assign res_valid = (state_q == RESP);
    assign res_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_arb.sv
// Randomized and directed self-checking bench for addsub_arb against an arithmetic model.
module tb_addsub_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_s = 1'b0, req1_s = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [8:0] res_data;
    logic       res_id;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int last_gnt = 1;
    int txn = 0;

    always #5 clk = ~clk;

    addsub_arb #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_s     (req0_s),
        .req1_s     (req1_s),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0d exp=%0d", tag, txn, got, exp);
        end
    endtask

    function automatic int model_res(input int a, input int b, input int s);
        if (s != 0) return (a - b + 512) % 512;
        return a + b;
    endfunction

    function automatic int model_winner(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ADDSUB_ARB_RR_EN
            return (last_gnt == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rvalid"}, 32'(res_valid), 0);
        check({tag, "_rdy0"}, 32'(req0_ready), 0);
        check({tag, "_rdy1"}, 32'(req1_ready), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_rdy0", 32'(req0_ready), 0);
        check("rst_rdy1", 32'(req1_ready), 0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_idle("rst");
        rst_n = 1'b1;
        last_gnt = 1;
    endtask

    // One full transaction: handshake, EXEC, RESP with optional stall, return to IDLE.
    task automatic issue(input bit v0, input bit v1,
                         input int a0, input int b0, input int s0,
                         input int a1, input int b1, input int s1,
                         input int stall, input bit scramble);
        int w, exp;
        @(negedge clk);
        req0_valid = v0; req0_a = 8'(a0); req0_b = 8'(b0); req0_s = 1'(s0);
        req1_valid = v1; req1_a = 8'(a1); req1_b = 8'(b1); req1_s = 1'(s1);
        res_ready = 1'b1;
        #1;
        w = model_winner(v0, v1);
        exp = (w == 0) ? model_res(a0, b0, s0) : model_res(a1, b1, s1);
        check("hs_rdy0", 32'(req0_ready), (w == 0) ? 1 : 0);
        check("hs_rdy1", 32'(req1_ready), (w == 1) ? 1 : 0);
        last_gnt = w;
        @(negedge clk);
        check("exec_busy", 32'(busy), 1);
        check("exec_rvalid", 32'(res_valid), 0);
        check("exec_rdy0", 32'(req0_ready), 0);
        check("exec_rdy1", 32'(req1_ready), 0);
        if (scramble) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_s = ~req0_s;
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_s = ~req1_s;
            if (a0 == 159) req0_a = 8'd0;
        end
        res_ready = (stall == 0);
        @(negedge clk);
        check("resp_rvalid", 32'(res_valid), 1);
        check("resp_data", 32'(res_data), exp);
        check("resp_id", 32'(res_id), w);
        for (int k = 1; k < stall; k++) begin
            @(negedge clk);
            check("stall_rvalid", 32'(res_valid), 1);
            check("stall_data", 32'(res_data), exp);
            check("stall_id", 32'(res_id), w);
            check("stall_rdy0", 32'(req0_ready), 0);
            check("stall_rdy1", 32'(req1_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check_idle("post");
        $display("txn %0d v=%0d%0d win=%0d exp=%0d got=%0d id=%0d stall=%0d",
                 txn, v0, v1, w, exp, res_data, res_id, stall);
        txn++;
    endtask

    task automatic reset_in_exec();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd159; req0_b = 8'd250; req0_s = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("rx_rdy0", 32'(req0_ready), 1);
        @(negedge clk);
        check("rx_busy", 32'(busy), 1);
        rst_n = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        check_idle("rx");
        rst_n = 1'b1;
        last_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rx_norsp", 32'(res_valid), 0);
        end
        $display("txn %0d reset during EXEC, op discarded", txn);
        txn++;
    endtask

    initial begin
        do_reset();
        issue(1, 0, 159, 250, 0, 0, 0, 0, 0, 0);
        issue(0, 1, 0, 0, 0, 159, 250, 1, 0, 0);
        issue(0, 1, 0, 0, 0, 20, 104, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 20, 104, 0, 20, 104, 1, 0, 0);
        end
        issue(1, 0, 159, 250, 0, 0, 0, 0, 5, 0);
        reset_in_exec();
        issue(1, 0, 159, 250, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            issue(sel[0], sel[1],
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
